// File: rtl/stream_cfg_apply.sv
// Ready/valid config sink that applies each word to a target IP through a halt/ack/apply/settle/release handshake.
// Optional build macro CFG_APPLY_TIMEOUT_EN adds a halt-ack timeout with a sticky timeout_o flag.
module stream_cfg_apply #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter type         T              = logic [DATA_WIDTH-1:0],
  parameter T            RESET_CFG      = '0,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  T                     data_i,
  output T                     cfg_o,
  output logic                 cfg_update_o,
  output logic                 halt_req_o,
  input  logic                 halt_ack_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] apply_cnt_o,
  output logic                 timeout_o,
  input  logic                 timeout_clr_i
);

  localparam int unsigned SCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_APPLY,
    S_SETTLE,
    S_RELEASE
  } state_e;

  state_e               state_q, state_d;
  T                     cfg_q, cfg_d;
  logic                 upd_q, upd_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic                 timeout_q, timeout_d;

`ifdef CFG_APPLY_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    upd_d     = 1'b0;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    // Without the timeout feature nothing ever sets this flop, so it stays 0.
    timeout_d = timeout_q & ~timeout_clr_i;
`ifdef CFG_APPLY_TIMEOUT_EN
    tmo_cnt_d = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (valid_i) state_d = S_HALT;
      end
      S_HALT: begin
        if (halt_ack_i) begin
          state_d = S_APPLY;
`ifdef CFG_APPLY_TIMEOUT_EN
        end else if (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;  // assigned after the clear, so a same-cycle set wins
          state_d   = S_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
`endif
        end
      end
      S_APPLY: begin
        state_d = S_RELEASE;
        if (valid_i) begin
          cfg_d = data_i;
          upd_d = 1'b1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (SETTLE_CYCLES > 0) begin
            state_d  = S_SETTLE;
            settle_d = SCW'(SETTLE_CYCLES);
          end
        end
      end
      S_SETTLE: begin
        if (settle_q <= SCW'(1)) state_d = S_RELEASE;
        else                     settle_d = settle_q - SCW'(1);
      end
      S_RELEASE: begin
        if (!halt_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cfg_q     <= RESET_CFG;
      upd_q     <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      timeout_q <= 1'b0;
`ifdef CFG_APPLY_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      timeout_q <= timeout_d;
`ifdef CFG_APPLY_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign ready_o      = (state_q == S_APPLY);
  assign halt_req_o   = (state_q == S_HALT) || (state_q == S_APPLY) || (state_q == S_SETTLE);
  assign busy_o       = (state_q != S_IDLE);
  assign cfg_o        = cfg_q;
  assign cfg_update_o = upd_q;
  assign apply_cnt_o  = cnt_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_stream_cfg_apply.sv
// Directed bench for stream_cfg_apply: reset idle, single apply, data overwrite in HALT, back-to-back words,
// counter wrap, APPLY without valid, halt-ack timeout (CFG_APPLY_TIMEOUT_EN) and reset during SETTLE.
module tb_stream_cfg_apply;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic [7:0] cfg_o;
  logic       cfg_update_o;
  logic       halt_req_o;
  logic       halt_ack_i;
  logic       busy_o;
  logic [1:0] apply_cnt_o;
  logic       timeout_o;
  logic       timeout_clr_i;

  int n_chk = 0;
  int n_err = 0;

  stream_cfg_apply #(
    .DATA_WIDTH    (8),
    .RESET_CFG     (8'h5C),
    .SETTLE_CYCLES (4),
    .CNT_WIDTH     (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .cfg_o        (cfg_o),
    .cfg_update_o (cfg_update_o),
    .halt_req_o   (halt_req_o),
    .halt_ack_i   (halt_ack_i),
    .busy_o       (busy_o),
    .apply_cnt_o  (apply_cnt_o),
    .timeout_o    (timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Target follows halt_req_o one cycle later; drops valid once the word is applied.
  task automatic apply_word(input logic [7:0] d, output int pulses, output bit done);
    valid_i = 1'b1;
    data_i  = d;
    pulses  = 0;
    done    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cfg_update_o) begin
        pulses++;
        valid_i = 1'b0;
      end
      halt_ack_i = halt_req_o;
      if (pulses > 0 && !busy_o) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  pulses;
    int  halt_hi;
    bit  done;
    bit  gap_low;
    bit  idle_ok;

    rst_ni = 1'b0; valid_i = 1'b0; data_i = 8'h00; halt_ack_i = 1'b0; timeout_clr_i = 1'b0;
    tick(); tick();
    chk("rst_cfg", cfg_o, 8'h5C);
    chk("rst_ready", ready_o, 0);
    chk("rst_upd", cfg_update_o, 0);
    chk("rst_halt", halt_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", apply_cnt_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_ni = 1'b1;

    // Idle with valid low: nothing moves
    idle_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o || halt_req_o || ready_o || cfg_update_o || cfg_o !== 8'h5C || apply_cnt_o !== 2'd0)
        idle_ok = 1'b0;
    end
    chk("idle_quiet", idle_ok, 1);

    // Single word 0xA5, ack two cycles after halt request
    valid_i = 1'b1; data_i = 8'hA5;
    tick();
    chk("b_halt_entry", {busy_o, halt_req_o, ready_o}, 3'b110);
    tick(); tick();
    halt_ack_i = 1'b1;
    chk("b_halt_wait_ready", ready_o, 0);
    tick();
    chk("b_apply_ready", ready_o, 1);
    chk("b_apply_cfg_old", cfg_o, 8'h5C);
    tick();
    valid_i = 1'b0;
    chk("b_pulse_cfg", cfg_o, 8'hA5);
    chk("b_pulse_upd", cfg_update_o, 1);
    chk("b_pulse_ready", ready_o, 0);
    chk("b_pulse_cnt", apply_cnt_o, 1);
    halt_hi = halt_req_o ? 1 : 0;
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (halt_req_o) halt_hi++;
      if (cfg_update_o) pulses++;
    end
    chk("b_settle_halt_cycles", halt_hi, 4);
    chk("b_single_pulse", pulses, 1);
    tick();
    chk("b_release_halt", halt_req_o, 0);
    chk("b_release_busy", busy_o, 1);
    halt_ack_i = 1'b0;
    tick();
    chk("b_idle_busy", busy_o, 0);
    chk("b_idle_cnt", apply_cnt_o, 1);

    // Data overwritten while halted; only the APPLY-cycle value lands
    valid_i = 1'b1; data_i = 8'h01;
    tick();
    pulses = 0;
    data_i = 8'h02;
    tick();
    data_i = 8'h03;
    tick(); tick(); tick();
    if (cfg_update_o) pulses++;
    halt_ack_i = 1'b1;
    tick();
    chk("c_apply_ready", ready_o, 1);
    chk("c_apply_cfg_old", cfg_o, 8'hA5);
    tick();
    valid_i = 1'b0;
    chk("c_cfg", cfg_o, 8'h03);
    chk("c_cnt", apply_cnt_o, 2);
    if (cfg_update_o) pulses++;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_update_o) pulses++;
      halt_ack_i = halt_req_o;
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("c_done", done, 1);
    chk("c_pulses", pulses, 1);
    chk("c_cfg_final", cfg_o, 8'h03);

    // Valid held across two words: two full sequences with a low gap on halt_req
    valid_i = 1'b1; data_i = 8'h10;
    pulses = 0; gap_low = 1'b0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cfg_update_o) begin
        pulses++;
        if (pulses == 1) begin
          chk("d_first_cfg", cfg_o, 8'h10);
          data_i = 8'h20;
        end else begin
          chk("d_second_cfg", cfg_o, 8'h20);
          valid_i = 1'b0;
        end
      end
      if (pulses == 1 && !halt_req_o) gap_low = 1'b1;
      halt_ack_i = halt_req_o;
      if (pulses == 2 && !busy_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("d_done", done, 1);
    chk("d_pulses", pulses, 2);
    chk("d_gap_low", gap_low, 1);
    chk("d_cnt_wrap", apply_cnt_o, 0);

    // APPLY reached with valid low: no update, no count, straight to RELEASE
    valid_i = 1'b1; data_i = 8'h99;
    tick();
    valid_i = 1'b0;
    halt_ack_i = 1'b1;
    tick();
    chk("e_apply_ready", ready_o, 1);
    tick();
    chk("e_release_halt", halt_req_o, 0);
    chk("e_release_busy", busy_o, 1);
    chk("e_no_upd", cfg_update_o, 0);
    chk("e_cfg_kept", cfg_o, 8'h20);
    chk("e_cnt_kept", apply_cnt_o, 0);
    halt_ack_i = 1'b0;
    tick();
    chk("e_idle", busy_o, 0);

    // Fifth apply wraps the 2-bit counter to 1
    apply_word(8'h42, pulses, done);
    chk("w_done", done, 1);
    chk("w_pulses", pulses, 1);
    chk("w_cfg", cfg_o, 8'h42);
    chk("w_cnt", apply_cnt_o, 1);

`ifdef CFG_APPLY_TIMEOUT_EN
    // Ack never arrives: timeout after 8 HALT cycles, then retry
    halt_ack_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h77;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t_before", {timeout_o, halt_req_o}, 2'b01);
    tick();
    chk("t_flag", timeout_o, 1);
    chk("t_release", halt_req_o, 0);
    chk("t_cfg_kept", cfg_o, 8'h42);
    tick();
    chk("t_idle", busy_o, 0);
    tick();
    chk("t_retry", halt_req_o, 1);
    chk("t_sticky", timeout_o, 1);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    chk("t_cleared", timeout_o, 0);
    valid_i = 1'b0;
    halt_ack_i = 1'b1;
    tick(); tick();
    halt_ack_i = 1'b0;
    tick();
    chk("t_back_idle", busy_o, 0);
    chk("t_cnt_kept", apply_cnt_o, 1);
`else
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    chk("t_tied_low", timeout_o, 0);
`endif

    // Async reset in the middle of SETTLE
    valid_i = 1'b1; data_i = 8'h3C;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      halt_ack_i = halt_req_o;
      if (cfg_update_o) begin
        done = 1'b1;
        break;
      end
    end
    valid_i = 1'b0;
    chk("g_reached_settle", done, 1);
    tick();
    chk("g_settle_halt", halt_req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("g_rst_halt", halt_req_o, 0);
    chk("g_rst_busy", busy_o, 0);
    chk("g_rst_cfg", cfg_o, 8'h5C);
    chk("g_rst_cnt", apply_cnt_o, 0);
    halt_ack_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("g_after_rst_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
